// File: rtl/block_stats_pkg.sv
// rtl/block_stats_pkg.sv - shared types and constant functions for block_stats
package block_stats_pkg;

  // fractional bits of the mean reciprocal; one extra bit holds RECIP=1.0 for 1x1 blocks
  localparam int RECIP_FRAC = 16;
  localparam int RECIP_W    = RECIP_FRAC + 1;

  typedef enum logic [1:0] {
    MODE_MEAN     = 2'd0,
    MODE_MAX      = 2'd1,
    MODE_MIX      = 2'd2,
    MODE_MEAN_ALT = 2'd3
  } stat_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } out_state_t;

  // width that holds a full block of saturated pixels without truncation
  function automatic int sum_width(input int data_w, input int blk_w, input int blk_h);
    return $clog2(blk_w * blk_h * ((1 << data_w) - 1) + 1);
  endfunction

  // round(2^RECIP_FRAC / pixels_per_block)
  function automatic int recip(input int blk_w, input int blk_h);
    int n;
    n = blk_w * blk_h;
    return ((1 << RECIP_FRAC) + n / 2) / n;
  endfunction

endpackage

// File: rtl/block_pos_counter.sv
// rtl/block_pos_counter.sv - video edge detection and block position tracking
module block_pos_counter #(
  parameter int DATA_W  = 8,
  parameter int BLK_W   = 32,
  parameter int BLK_H   = 36,
  parameter int N_BLK_X = 40,
  parameter int N_BLK_Y = 20,
  localparam int BX_W = $clog2(N_BLK_X + 1),
  localparam int BY_W = $clog2(N_BLK_Y + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  input  logic [DATA_W-1:0] gray,
  output logic              pix_en,
  output logic [DATA_W-1:0] pix_gray,
  output logic [BX_W-1:0]   pix_bx,
  output logic              swap,
  output logic [BY_W-1:0]   swap_by,
  output logic              vs_rise
);

  localparam int PX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int LY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(BLK_W - 1);
  localparam logic [LY_W-1:0] LY_LAST = LY_W'(BLK_H - 1);
  localparam logic [BX_W-1:0] BX_END  = BX_W'(N_BLK_X);
  localparam logic [BY_W-1:0] BY_END  = BY_W'(N_BLK_Y);

  logic              de_q, hs_q, vs_q, de_q2, hs_q2, vs_q2;
  logic [DATA_W-1:0] gray_q;
  logic [PX_W-1:0]   px_q, px_d;
  logic [BX_W-1:0]   bx_q, bx_d;
  logic [LY_W-1:0]   ly_q, ly_d;
  logic [BY_W-1:0]   by_q, by_d;
  logic              hs_rise, de_fall, bx_in, by_in;

  // one register stage on the inputs, a second stage for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q2  <= 1'b0;
      hs_q2  <= 1'b0;
      vs_q2  <= 1'b0;
      gray_q <= '0;
    end else begin
      de_q   <= de;
      hs_q   <= hs;
      vs_q   <= vs;
      de_q2  <= de_q;
      hs_q2  <= hs_q;
      vs_q2  <= vs_q;
      gray_q <= gray;
    end
  end

  assign hs_rise  = hs_q & ~hs_q2;
  assign de_fall  = ~de_q & de_q2;
  assign vs_rise  = vs_q & ~vs_q2;
  // the counters saturate at the block count, which marks out-of-range pixels and lines
  assign bx_in    = (bx_q != BX_END);
  assign by_in    = (by_q != BY_END);
  assign pix_en   = de_q & bx_in & by_in;
  assign pix_gray = gray_q;
  assign pix_bx   = bx_q;
  assign swap     = de_fall & by_in & (ly_q == LY_LAST);
  assign swap_by  = by_q;

  // next position: pixels on de, lines on the end of de, cleared by hs/vs
  always_comb begin
    px_d = px_q;
    bx_d = bx_q;
    ly_d = ly_q;
    by_d = by_q;
    if (vs_rise) begin
      px_d = '0;
      bx_d = '0;
      ly_d = '0;
      by_d = '0;
    end else begin
      if (hs_rise) begin
        px_d = '0;
        bx_d = '0;
      end else if (de_q && bx_in) begin
        if (px_q == PX_LAST) begin
          px_d = '0;
          bx_d = bx_q + BX_W'(1);
        end else begin
          px_d = px_q + PX_W'(1);
        end
      end
      if (de_fall && by_in) begin
        if (ly_q == LY_LAST) begin
          ly_d = '0;
          by_d = by_q + BY_W'(1);
        end else begin
          ly_d = ly_q + LY_W'(1);
        end
      end
    end
  end

  // position counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px_q <= '0;
      bx_q <= '0;
      ly_q <= '0;
      by_q <= '0;
    end else begin
      px_q <= px_d;
      bx_q <= bx_d;
      ly_q <= ly_d;
      by_q <= by_d;
    end
  end

endmodule

// File: rtl/block_stats.sv
// rtl/block_stats.sv - per-block luminance statistics; max path built under BLOCK_STATS_MAX_EN
module block_stats #(
  parameter int DATA_W  = 8,
  parameter int BLK_W   = 32,
  parameter int BLK_H   = 36,
  parameter int N_BLK_X = 40,
  parameter int N_BLK_Y = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  input  logic [DATA_W-1:0] gray,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] brightness,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_bx,
  output logic [5:0]        out_by,
  output logic              out_last,
  output logic              out_frame_last,
  output logic              overrun
);
  import block_stats_pkg::*;

  localparam int SUM_W  = sum_width(DATA_W, BLK_W, BLK_H);
  localparam int PROD_W = SUM_W + RECIP_W;
  localparam int BX_W   = $clog2(N_BLK_X + 1);
  localparam int BY_W   = $clog2(N_BLK_Y + 1);
  localparam int IX_W   = (N_BLK_X > 1) ? $clog2(N_BLK_X) : 1;
  localparam logic [IX_W-1:0]    IX_LAST = IX_W'(N_BLK_X - 1);
  localparam logic [5:0]         BY_LAST = 6'(N_BLK_Y - 1);
  localparam logic [RECIP_W-1:0] RECIP_K = RECIP_W'(recip(BLK_W, BLK_H));
  localparam logic [DATA_W-1:0]  D_MAX   = '1;

  logic              pix_en, swap, vs_rise, swap_take;
  logic [DATA_W-1:0] pix_gray;
  logic [BX_W-1:0]   pix_bx;
  logic [BY_W-1:0]   swap_by;
  logic [SUM_W-1:0]  acc_sum_q [N_BLK_X];
  logic [SUM_W-1:0]  acc_sum_d [N_BLK_X];
  logic [SUM_W-1:0]  shd_sum_q [N_BLK_X];
  logic [SUM_W-1:0]  shd_sum_d [N_BLK_X];
  out_state_t        state_q;
  logic              valid_q, overrun_q;
  logic [IX_W-1:0]   bx_q;
  logic [5:0]        by_q;
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] mean, stat;

  block_pos_counter #(
    .DATA_W (DATA_W),
    .BLK_W  (BLK_W),
    .BLK_H  (BLK_H),
    .N_BLK_X(N_BLK_X),
    .N_BLK_Y(N_BLK_Y)
  ) u_pos (
    .clk     (clk),
    .rstn    (rstn),
    .de      (de),
    .hs      (hs),
    .vs      (vs),
    .gray    (gray),
    .pix_en  (pix_en),
    .pix_gray(pix_gray),
    .pix_bx  (pix_bx),
    .swap    (swap),
    .swap_by (swap_by),
    .vs_rise (vs_rise)
  );

  // a completed row is only taken when the sequencer is free or finishing this cycle
  assign swap_take = swap & ((state_q == ST_IDLE) | (out_ready & (bx_q == IX_LAST)));

  // sum accumulators clear on every swap (taken or dropped); shadow loads on a taken swap
  always_comb begin
    for (int i = 0; i < N_BLK_X; i++) begin
      shd_sum_d[i] = swap_take ? acc_sum_q[i] : shd_sum_q[i];
      acc_sum_d[i] = acc_sum_q[i];
      if (swap || vs_rise) acc_sum_d[i] = '0;
      else if (pix_en && (pix_bx == BX_W'(i))) acc_sum_d[i] = acc_sum_q[i] + SUM_W'(pix_gray);
    end
  end

  // sum and shadow-sum registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_BLK_X; i++) begin
        acc_sum_q[i] <= '0;
        shd_sum_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BLK_X; i++) begin
        acc_sum_q[i] <= acc_sum_d[i];
        shd_sum_q[i] <= shd_sum_d[i];
      end
    end
  end

`ifdef BLOCK_STATS_MAX_EN
  logic [DATA_W-1:0] acc_max_q [N_BLK_X];
  logic [DATA_W-1:0] acc_max_d [N_BLK_X];
  logic [DATA_W-1:0] shd_max_q [N_BLK_X];
  logic [DATA_W-1:0] shd_max_d [N_BLK_X];
  logic [DATA_W:0]   mix;

  // running maxima follow the same clear/shadow rules as the sums
  always_comb begin
    for (int i = 0; i < N_BLK_X; i++) begin
      shd_max_d[i] = swap_take ? acc_max_q[i] : shd_max_q[i];
      acc_max_d[i] = acc_max_q[i];
      if (swap || vs_rise) acc_max_d[i] = '0;
      else if (pix_en && (pix_bx == BX_W'(i)) && (pix_gray > acc_max_q[i])) acc_max_d[i] = pix_gray;
    end
  end

  // max and shadow-max registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_BLK_X; i++) begin
        acc_max_q[i] <= '0;
        shd_max_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BLK_X; i++) begin
        acc_max_q[i] <= acc_max_d[i];
        shd_max_q[i] <= shd_max_d[i];
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
`endif

  // reduce: mean via reciprocal multiply, mode select, brightness offset floored at 0
  always_comb begin
    prod = PROD_W'(shd_sum_q[bx_q]) * PROD_W'(RECIP_K);
    if (|prod[PROD_W-1:RECIP_FRAC+DATA_W]) mean = D_MAX;
    else mean = prod[RECIP_FRAC +: DATA_W];
    stat = mean;
`ifdef BLOCK_STATS_MAX_EN
    mix = ({1'b0, mean} + {1'b0, shd_max_q[bx_q]}) >> 1;
    case (stat_mode_t'(mode))
      MODE_MAX: stat = shd_max_q[bx_q];
      MODE_MIX: stat = mix[DATA_W-1:0];
      default:  stat = mean;
    endcase
`endif
    out_data = (stat > brightness) ? (stat - brightness) : '0;
  end

  // output sequencer: loads a row on a taken swap and walks out_bx on each handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      bx_q      <= '0;
      by_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (swap) begin
            state_q <= ST_SEND;
            valid_q <= 1'b1;
            bx_q    <= '0;
            by_q    <= 6'(swap_by);
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (bx_q == IX_LAST) begin
              bx_q <= '0;
              if (swap) begin
                by_q <= 6'(swap_by);
              end else begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
              end
            end else begin
              bx_q <= bx_q + IX_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
      if (vs_rise) overrun_q <= 1'b0;
      else if (swap && !swap_take) overrun_q <= 1'b1;
    end
  end

  assign out_valid      = valid_q;
  assign out_bx         = 6'(bx_q);
  assign out_by         = by_q;
  assign out_last       = valid_q & (bx_q == IX_LAST);
  assign out_frame_last = out_last & (by_q == BY_LAST);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_block_stats.sv
// tb/tb_block_stats.sv - randomized self-checking bench for block_stats against a block-statistics model
module tb_block_stats;

  localparam int DW = 8;
  localparam int BW = 4;
  localparam int BH = 2;
  localparam int NX = 3;
  localparam int NY = 2;
  localparam int MODEL_RECIP = (65536 + (BW * BH) / 2) / (BW * BH);
`ifdef BLOCK_STATS_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [DW-1:0] gray = '0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] brightness = '0;
  logic          out_ready = 1'b1;
  logic          out_valid, out_last, out_frame_last, overrun;
  logic [DW-1:0] out_data;
  logic [5:0]    out_bx, out_by;

  int n_cmp = 0;
  int n_bad = 0;
  int pix [0:4][0:13];
  int exp_q[$];
  int obs_q[$];
  int line_gap = 8;
  bit done_drive;
  int d0;
  int wait_k;

  block_stats #(.DATA_W(DW), .BLK_W(BW), .BLK_H(BH), .N_BLK_X(NX), .N_BLK_Y(NY)) dut (
    .clk(clk), .rstn(rstn), .de(de), .hs(hs), .vs(vs), .gray(gray), .mode(mode),
    .brightness(brightness), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bx(out_bx), .out_by(out_by), .out_last(out_last), .out_frame_last(out_frame_last),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pack(input int d, input int bx, input int by, input int l, input int fl);
    return d | (bx << 8) | (by << 14) | (l << 20) | (fl << 21);
  endfunction

  // record every completed handshake
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready)
      obs_q.push_back(pack(int'(out_data), int'(out_bx), int'(out_by), int'(out_last), int'(out_frame_last)));
  end

  // reference: statistic of one block straight from the pixel array
  function automatic int model_stat(input int bx, input int by, input int md, input int br);
    int sum, mx, mean, st, p;
    sum = 0;
    mx = 0;
    for (int l = 0; l < BH; l++) begin
      for (int c = 0; c < BW; c++) begin
        p = pix[by * BH + l][bx * BW + c];
        sum += p;
        if (p > mx) mx = p;
      end
    end
    mean = (sum * MODEL_RECIP) >> 16;
    if (mean > 255) mean = 255;
    st = mean;
    if (MAX_EN && md == 1) st = mx;
    if (MAX_EN && md == 2) st = (mean + mx) / 2;
    return (st > br) ? st - br : 0;
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int by = 0; by < NY; by++)
      for (int bx = 0; bx < NX; bx++)
        exp_q.push_back(pack(model_stat(bx, by, int'(mode), int'(brightness)), bx, by,
                             int'(bx == NX - 1), int'(bx == NX - 1 && by == NY - 1)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_flat(input int v);
    for (int l = 0; l < 5; l++)
      for (int c = 0; c < 14; c++) pix[l][c] = v;
  endtask

  task automatic fill_rand();
    for (int l = 0; l < 5; l++)
      for (int c = 0; c < 14; c++) pix[l][c] = int'($urandom_range(0, 255));
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    repeat (2) tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drive_frame(input int w, input int lines);
    vs_pulse();
    for (int l = 0; l < lines; l++) begin
      hs = 1'b1;
      repeat (2) tick();
      hs = 1'b0;
      repeat (2) tick();
      for (int c = 0; c < w; c++) begin
        de = 1'b1;
        gray = DW'(pix[l][c]);
        tick();
      end
      de = 1'b0;
      gray = '0;
      repeat (line_gap) tick();
    end
  endtask

  task automatic wait_outputs(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_outputs(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("%s_item%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input string tag, input int w, input int lines);
    obs_q.delete();
    build_expected();
    drive_frame(w, lines);
    wait_outputs(exp_q.size());
    compare_outputs(tag);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    rstn = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_bx", int'(out_bx), 0);
    check_eq("rst_by", int'(out_by), 0);
    check_eq("rst_valid_post", int'(out_valid), 0);
    check_eq("rst_last", int'(out_last), 0);

    // flat frame
    fill_flat(100);
    mode = 2'd0;
    brightness = '0;
    run_frame("flat100", 12, 4);

    // block (1,0) holds 0..7
    fill_rand();
    for (int i = 0; i < 8; i++) pix[i / 4][4 + i % 4] = i;
    mode = 2'd1;
    run_frame("blk_max", 12, 4);
    if (obs_q.size() > 1) check_eq("blk10_max", obs_q[1] & 255, MAX_EN ? 7 : 3);
    mode = 2'd2;
    run_frame("blk_mix", 12, 4);
    if (obs_q.size() > 1) check_eq("blk10_mix", obs_q[1] & 255, MAX_EN ? 5 : 3);
    mode = 2'd3;
    run_frame("blk_mean3", 12, 4);

    // brightness offset and floor
    mode = 2'd0;
    fill_flat(255);
    brightness = 8'd20;
    run_frame("bright_255", 12, 4);
    if (obs_q.size() > 0) check_eq("bright_235", obs_q[0] & 255, 235);
    fill_flat(10);
    run_frame("bright_floor", 12, 4);
    if (obs_q.size() > 0) check_eq("bright_zero", obs_q[0] & 255, 0);
    brightness = '0;

    // back-pressure for 5 cycles after the first valid
    fill_rand();
    obs_q.delete();
    build_expected();
    out_ready = 1'b0;
    fork
      drive_frame(12, 4);
      begin
        wait_k = 0;
        while (!out_valid && wait_k < 1000) begin
          @(negedge clk);
          wait_k++;
        end
        check_eq("stall_valid_seen", int'(out_valid), 1);
        d0 = int'(out_data);
        check_eq("stall_first_data", d0, exp_q[0] & 255);
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_bx", int'(out_bx), 0);
          check_eq("stall_data", int'(out_data), d0);
          check_eq("stall_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(exp_q.size());
    compare_outputs("stall");

    // overrun: row 1 arrives while row 0 is still held
    fill_rand();
    obs_q.delete();
    build_expected();
    repeat (3) void'(exp_q.pop_back());
    out_ready = 1'b0;
    drive_frame(12, 4);
    @(negedge clk);
    check_eq("ovr_flag", int'(overrun), 1);
    check_eq("ovr_valid", int'(out_valid), 1);
    check_eq("ovr_by", int'(out_by), 0);
    check_eq("ovr_bx", int'(out_bx), 0);
    out_ready = 1'b1;
    wait_outputs(exp_q.size());
    compare_outputs("ovr");
    check_eq("ovr_idle", int'(out_valid), 0);
    check_eq("ovr_sticky", int'(overrun), 1);
    vs_pulse();
    repeat (2) tick();
    @(negedge clk);
    check_eq("ovr_vs_clear", int'(overrun), 0);

    // oversize line and frame
    fill_rand();
    run_frame("oversize", 14, 5);

    // asynchronous reset while a row is held
    fill_rand();
    out_ready = 1'b0;
    drive_frame(12, 4);
    @(negedge clk);
    check_eq("pre_rst_valid", int'(out_valid), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("async_rst_valid", int'(out_valid), 0);
    check_eq("async_rst_overrun", int'(overrun), 0);
    check_eq("async_rst_by", int'(out_by), 0);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    fill_flat(77);
    mode = 2'd0;
    run_frame("post_rst", 12, 4);

    // randomized frames with random back-pressure
    line_gap = 24;
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      mode = 2'($urandom_range(0, 3));
      brightness = DW'($urandom_range(0, 63));
      obs_q.delete();
      build_expected();
      done_drive = 1'b0;
      fork
        begin
          drive_frame(12, 4);
          done_drive = 1'b1;
        end
        begin
          while (!done_drive) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      out_ready = 1'b1;
      wait_outputs(exp_q.size());
      compare_outputs($sformatf("rand%0d", f));
      check_eq($sformatf("rand%0d_no_overrun", f), int'(overrun), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_stats.md
# block_stats

Parametrised per-block luminance statistics engine for the local-dimming path; successor to the fixed 40×20 block mean stage. It sits between grayscale conversion and the backlight/LED driver. It derives block position internally from `de`/`hs`/`vs` and accumulates a per-block sum, plus an optional maximum. At the end of every block row it streams one statistic per block over a valid/ready interface, with brightness offset applied.

## Interface
- `DATA_W`, 8: pixel gray width.
- `BLK_W`, 32: block width in pixels.
- `BLK_H`, 36: block height in lines.
- `N_BLK_X`, 40: blocks per row.
- `N_BLK_Y`, 20: block rows per frame.
- `clk` in 1: pixel clock.
- `rstn` in 1: asynchronous, active-low reset; single clock domain.
- `de`, `hs`, `vs` in 1: video timing, active high.
- `gray` in DATA_W: pixel, valid when `de`=1.
- `mode` in 2: 0 = mean, 1 = max, 2 = (mean+max)>>1, 3 = mean.
- `brightness` in DATA_W: offset subtracted from the result, floored at 0.
- `out_valid` out 1: statistic available.
- `out_ready` in 1: consumer accepts.
- `out_data` out DATA_W: block statistic.
- `out_bx` out 6: block column.
- `out_by` out 6: block row.
- `out_last` out 1: last block of the row (`out_bx`=N_BLK_X-1).
- `out_frame_last` out 1: last block of the frame.
- `overrun` out 1: sticky; a row completed while the previous row was still streaming.

## Operation
- Edges are detected on registered copies of the inputs: `vs_rise`, `hs_rise`, `de_fall`.
- `vs_rise` clears the pixel, line, block and accumulator state and clears `overrun`. It does not abort a send in progress.
- Position counters advance as follows:
  - Pixel-in-block and block-column counters advance on `de` and clear on `hs_rise`.
  - Line-in-block and block-row counters advance on `de_fall`.
- Pixels beyond N_BLK_X·BLK_W in a line, and lines beyond N_BLK_Y·BLK_H in a frame, are ignored. Partial blocks never emit.
- Accumulators: N_BLK_X sums of width SUM_W = clog2(BLK_W·BLK_H·(2^DATA_W−1)+1), with no intermediate truncation. Optional N_BLK_X maxima of width DATA_W.
- Bank swap happens on the `de_fall` that ends line BLK_H−1 of a block row.
  - All sums and maxima are copied into the shadow bank, `out_by` is latched, and the accumulators clear in the same cycle.
  - Pixels of the next line accumulate from zero.
- Output FSM states are IDLE and SEND.
  - IDLE→SEND on a bank swap. `out_bx`=0, `out_valid`=1.
  - In SEND, `out_valid && out_ready` increments `out_bx`. On `out_last` it returns to IDLE.
  - `out_valid`, `out_bx` and `out_by` hold stable while `out_ready`=0.
- If a bank swap arrives in SEND, the new row is dropped, the shadow bank is kept, `overrun` is set, and the accumulators still clear.
- Arithmetic:
  - `mean = (sum·RECIP)>>16`, with RECIP = round(2^16/(BLK_W·BLK_H)), saturated to 2^DATA_W−1.
  - The selected statistic minus `brightness` is floored at 0 and gives `out_data`.
  - `out_data` is combinational from `shadow[out_bx]`, `mode` and `brightness`.
- Reset values: `out_valid`=0, `out_bx`=0, `out_by`=0, `overrun`=0, FSM=IDLE, all accumulators and the shadow bank 0.

## Timing
- Pixel-to-accumulator latency: 1 cycle, since `gray` and `de` are registered once.
- Swap occurs in the cycle in which `de_fall` is seen. `out_valid` rises the following cycle.
- With `out_ready` held at 1, a row streams in N_BLK_X consecutive cycles.
- `out_bx` changes exactly one cycle after each handshake.
- Swap and the final handshake in the same cycle: the handshake completes, then the new row is sent. No overrun.
- `rstn` low mid-stream: all state clears asynchronously and `out_valid` drops immediately.

## Configuration
- `BLOCK_STATS_MAX_EN` defined:
  - Max accumulators and shadow maxima are built.
  - Modes 1 and 2 are as specified.
- `BLOCK_STATS_MAX_EN` undefined:
  - No max storage is built.
  - Modes 1 and 2 return the mean.

## Structure
- `block_stats_pkg` holds:
  - the `stat_mode_t` enum;
  - the `sum_width()` and `recip()` constant functions;
  - the RECIP fractional width of 16.
- Sub-module `block_pos_counter`: edge detection, pixel, line and block counters, and the in-range, swap and `vs_rise` strobes.
- The top level holds the accumulators, the shadow bank, the FSM and the reduce datapath.

## Test plan
Bench parameters: BLK_W=4, BLK_H=2, N_BLK_X=3, N_BLK_Y=2, DATA_W=8.
- Flat frame, `gray`=100, `mode`=0, `brightness`=0, `out_ready`=1 → 6 outputs of 100. `out_last` on bx=2. `out_frame_last` on (2,1).
- Block (1,0) holds pixels 0..7, `mode`=1 → 7. `mode`=2 → (3+7)>>1=5. With `BLOCK_STATS_MAX_EN` undefined, both give 3.
- `gray`=255, `brightness`=20 → 235. `gray`=10, `brightness`=20 → 0.
- `out_ready` low for 5 cycles after the first valid → `out_bx`=0 and `out_data` held stable. Sequence 0,1,2 is then delivered, with no loss.
- `out_ready`=0 through the next row swap → `overrun`=1, row 0 data retained, row 1 dropped. `vs_rise` → `overrun`=0.
- Line of 14 active pixels and 5 lines per frame → extra pixels and lines are ignored, and exactly 6 outputs are produced.
